branch_predictor: RTL and testbench

- Parametrised branch predictor for the next-generation pipelined MIPS core.
- Branches are currently resolved in ID with an unconditional IF/ID flush. This block predicts direction and target in IF, so correctly predicted branches and jumps cost no flush.
- Resolution logic in ID writes outcomes back through an update port.
- Structure: tagged direct-mapped BTB, saturating direction counters per entry, optional gshare index hashing, and mispredict statistics counters.

---
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor.sv | 74 +++++++
 tb/tb_branch_predictor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup, update and status bundle between the pipeline and the branch predictor
interface branch_predictor_if #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64,
  parameter int HIST_W = 0,
  parameter int STAT_W = 32
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW = HIST_W > 0 ? HIST_W : 1;
  logic clear;
  logic [XLEN-1:0] pc_if;
  logic pred_hit;
  logic pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [IDX_W-1:0] pred_idx;
  logic upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [XLEN-1:0] upd_pc;
  logic upd_taken;
  logic [XLEN-1:0] upd_target;
  logic upd_mispred;
  logic [GW-1:0] ghr;
  logic [STAT_W-1:0] stat_upd;
  logic [STAT_W-1:0] stat_mispred;
  modport master (
    output clear, pc_if, upd_valid, upd_idx, upd_pc, upd_taken, upd_target, upd_mispred,
    input pred_hit, pred_taken, pred_target, pred_idx, ghr, stat_upd, stat_mispred
  );
  modport slave (
    input clear, pc_if, upd_valid, upd_idx, upd_pc, upd_taken, upd_target, upd_mispred,
    output pred_hit, pred_taken, pred_target, pred_idx, ghr, stat_upd, stat_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: tagged direct-mapped BTB with saturating direction counters, optional gshare and mispredict stats
module branch_predictor #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2,
  parameter int HIST_W = 0,
  parameter int STAT_W = 32
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW = HIST_W > 0 ? HIST_W : 1;
  localparam logic [CNT_W-1:0] weak_taken = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] weak_not_taken = CNT_W'((1 << (CNT_W - 1)) - 1);
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] target;
    logic [CNT_W-1:0] cnt;
  } entry_t;
  localparam entry_t empty = '{valid: 1'b0, tag: '0, target: '0, cnt: weak_not_taken};
  entry_t tbl [ENTRIES];
  entry_t cur;
  entry_t old;
  logic [GW-1:0] ghr;
  logic [STAT_W-1:0] n_upd;
  logic [STAT_W-1:0] n_mis;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;
  logic [IDX_W-1:0] idx;
  logic hit;
  logic upd_hit;
  logic unused_bits;
  assign look_tag = bp.pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign idx = bp.pc_if[IDX_W+1:2] ^ IDX_W'(ghr);
  assign cur = tbl[idx];
  assign old = tbl[bp.upd_idx];
  assign hit = cur.valid && cur.tag == look_tag;
  assign upd_hit = old.valid && old.tag == upd_tag;
  assign bp.pred_idx = idx;
  assign bp.pred_hit = hit;
  assign bp.pred_taken = hit && cur.cnt[CNT_W-1];
  assign bp.pred_target = hit ? cur.target : '0;
  assign bp.ghr = ghr;
  assign bp.stat_upd = n_upd;
  assign bp.stat_mispred = n_mis;
  assign unused_bits = ^{bp.pc_if, bp.upd_pc};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= empty;
      ghr <= '0;
      n_upd <= '0;
      n_mis <= '0;
    end else if (bp.clear) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= empty;
      ghr <= '0;
      n_upd <= '0;
      n_mis <= '0;
    end else if (bp.upd_valid) begin
      if (upd_hit) begin
        tbl[bp.upd_idx].cnt <= bp.upd_taken ? (&old.cnt ? old.cnt : old.cnt + CNT_W'(1))
                                             : (|old.cnt ? old.cnt - CNT_W'(1) : old.cnt);
        if (bp.upd_taken) tbl[bp.upd_idx].target <= bp.upd_target;
      end else if (bp.upd_taken)
        tbl[bp.upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: bp.upd_target, cnt: weak_taken};
      if (HIST_W > 0) ghr <= GW'({ghr, bp.upd_taken});
      if (~&n_upd) n_upd <= n_upd + STAT_W'(1);
      if (bp.upd_mispred && ~&n_mis) n_mis <= n_mis + STAT_W'(1);
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for a bimodal and a gshare branch_predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    int sel;
    string name;
    logic [63:0] v;
  } exp_t;
  exp_t q[$];
  branch_predictor_if #(.HIST_W(0)) i0();
  branch_predictor_if #(.HIST_W(4)) i1();
  branch_predictor #(.HIST_W(0)) dut0 (.clk(clk), .reset(reset), .bp(i0));
  branch_predictor #(.HIST_W(4)) dut1 (.clk(clk), .reset(reset), .bp(i1));
  always #5 clk = ~clk;
  function automatic logic [63:0] obs(int sel);
    case (sel)
      0: return 64'(i0.pred_hit);
      1: return 64'(i0.pred_taken);
      2: return 64'(i0.pred_target);
      3: return 64'(i0.pred_idx);
      4: return 64'(i0.stat_upd);
      5: return 64'(i0.stat_mispred);
      6: return 64'(i0.ghr);
      10: return 64'(i1.pred_hit);
      11: return 64'(i1.pred_taken);
      12: return 64'(i1.pred_target);
      13: return 64'(i1.pred_idx);
      14: return 64'(i1.stat_upd);
      15: return 64'(i1.stat_mispred);
      16: return 64'(i1.ghr);
      default: return '1;
    endcase
  endfunction
  task automatic push(int d, int sel, string name, logic [63:0] v);
    q.push_back('{d * 10 + sel, $sformatf("d%0d_%s", d, name), v});
  endtask
  task automatic drain;
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] o;
      e = q.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.v) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.name, o, e.v);
      end
    end
  endtask
  task automatic look(int d, logic [31:0] pc, logic hit, logic taken, logic [31:0] tgt, int idx);
    if (d == 0) i0.pc_if = pc;
    else i1.pc_if = pc;
    push(d, 0, "hit", 64'(hit));
    push(d, 1, "taken", 64'(taken));
    push(d, 2, "target", 64'(tgt));
    push(d, 3, "idx", 64'(idx));
    #1;
    drain();
  endtask
  task automatic stats(int d, int nu, int nm);
    push(d, 4, "stat_upd", 64'(nu));
    push(d, 5, "stat_mispred", 64'(nm));
    drain();
  endtask
  task automatic ghr_chk(int d, int g);
    push(d, 6, "ghr", 64'(g));
    drain();
  endtask
  task automatic drive_upd(int d, int idx, logic [31:0] pc, logic taken, logic [31:0] tgt, logic mis);
    if (d == 0) begin
      i0.upd_valid = 1'b1;
      i0.upd_idx = 6'(idx);
      i0.upd_pc = pc;
      i0.upd_taken = taken;
      i0.upd_target = tgt;
      i0.upd_mispred = mis;
    end else begin
      i1.upd_valid = 1'b1;
      i1.upd_idx = 6'(idx);
      i1.upd_pc = pc;
      i1.upd_taken = taken;
      i1.upd_target = tgt;
      i1.upd_mispred = mis;
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    i0.upd_valid = 1'b0;
    i0.upd_mispred = 1'b0;
    i0.clear = 1'b0;
    i1.upd_valid = 1'b0;
    i1.upd_mispred = 1'b0;
    i1.clear = 1'b0;
  endtask
  task automatic upd(int d, int idx, logic [31:0] pc, logic taken, logic [31:0] tgt, logic mis);
    drive_upd(d, idx, pc, taken, tgt, mis);
    step();
  endtask
  initial begin
    i0.clear = 1'b0;
    i0.pc_if = 32'h00400010;
    i0.upd_valid = 1'b0;
    i0.upd_idx = '0;
    i0.upd_pc = '0;
    i0.upd_taken = 1'b0;
    i0.upd_target = '0;
    i0.upd_mispred = 1'b0;
    i1.clear = 1'b0;
    i1.pc_if = 32'h00400010;
    i1.upd_valid = 1'b0;
    i1.upd_idx = '0;
    i1.upd_pc = '0;
    i1.upd_taken = 1'b0;
    i1.upd_target = '0;
    i1.upd_mispred = 1'b0;
    #1 reset = 1'b0;
    look(0, 32'h00400010, 0, 0, 0, 4);
    stats(0, 0, 0);
    look(1, 32'h00400010, 0, 0, 0, 4);
    ghr_chk(1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();
    upd(0, 4, 32'h00400010, 1, 32'h00400040, 1);
    look(0, 32'h00400010, 1, 1, 32'h00400040, 4);
    repeat (3) upd(0, 4, 32'h00400010, 1, 32'h00400040, 0);
    look(0, 32'h00400010, 1, 1, 32'h00400040, 4);
    upd(0, 4, 32'h00400010, 0, 32'h0, 1);
    look(0, 32'h00400010, 1, 1, 32'h00400040, 4);
    upd(0, 4, 32'h00400010, 0, 32'h0, 1);
    look(0, 32'h00400010, 1, 0, 32'h00400040, 4);
    upd(0, 4, 32'h00400010, 0, 32'h0, 0);
    look(0, 32'h00400010, 1, 0, 32'h00400040, 4);
    upd(0, 4, 32'h00400010, 0, 32'h0, 0);
    look(0, 32'h00400010, 1, 0, 32'h00400040, 4);
    upd(0, 4, 32'h00400010, 1, 32'h00400040, 1);
    look(0, 32'h00400010, 1, 0, 32'h00400040, 4);
    stats(0, 9, 4);
    upd(0, 4, 32'h00401010, 1, 32'h00401100, 1);
    look(0, 32'h00400010, 0, 0, 0, 4);
    look(0, 32'h00401010, 1, 1, 32'h00401100, 4);
    upd(0, 8, 32'h00400020, 0, 32'h00400999, 0);
    look(0, 32'h00400020, 0, 0, 0, 8);
    i0.pc_if = 32'h00400080;
    drive_upd(0, 32, 32'h00400080, 1, 32'h00400123, 0);
    push(0, 0, "same_cycle_hit", 64'(0));
    #1;
    drain();
    step();
    look(0, 32'h00400080, 1, 1, 32'h00400123, 32);
    drive_upd(0, 4, 32'h00401010, 0, 32'h0, 1);
    i0.upd_valid = 1'b0;
    repeat (3) step();
    look(0, 32'h00401010, 1, 1, 32'h00401100, 4);
    stats(0, 12, 5);
    ghr_chk(0, 0);
    upd(1, 0, 32'h00500000, 1, 32'h00500100, 1);
    upd(1, 0, 32'h00500000, 0, 32'h0, 1);
    upd(1, 0, 32'h00500000, 1, 32'h00500100, 0);
    upd(1, 0, 32'h00500000, 1, 32'h00500100, 0);
    ghr_chk(1, 11);
    look(1, 32'h00400010, 0, 0, 0, 15);
    stats(1, 4, 2);
    upd(1, 15, 32'h00400010, 1, 32'h00400200, 0);
    ghr_chk(1, 7);
    look(1, 32'h00400020, 1, 1, 32'h00400200, 15);
    stats(1, 5, 2);
    i1.clear = 1'b1;
    drive_upd(1, 15, 32'h0040003C, 1, 32'h00400999, 1);
    step();
    ghr_chk(1, 0);
    stats(1, 0, 0);
    look(1, 32'h0040003C, 0, 0, 0, 15);
    look(1, 32'h00400020, 0, 0, 0, 8);
    look(0, 32'h00401010, 1, 1, 32'h00401100, 4);
    #1 reset = 1'b0;
    #1;
    push(0, 0, "async_hit", 64'(0));
    push(0, 1, "async_taken", 64'(0));
    push(0, 2, "async_target", 64'(0));
    push(0, 3, "async_idx", 64'(4));
    push(0, 4, "async_stat_upd", 64'(0));
    push(0, 5, "async_stat_mispred", 64'(0));
    drain();
    @(negedge clk) reset = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
